// File: rtl/pipelined_comp_alu.sv
// rtl/pipelined_comp_alu.sv - two-stage pipelined R-type execute unit with register file and writeback
// Optional operand forwarding from S1 on RAW hazards: define PIPE_ALU_FWD_EN.
module pipelined_comp_alu #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic              out_carry,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [5:0] SHIFT_LIMIT = 6'(DATA_W);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;

  function automatic logic [IDX_W-1:0] regIdx(input logic [4:0] field);
    return IDX_W'(32'(field) % REG_NUM);
  endfunction

  logic [DATA_W-1:0] regs [REG_NUM];

  logic [IDX_W-1:0]  rsIdx, rtIdx, rdIdx;
  logic              inLegal, stall, accept, rsHit, rtHit;
  logic [DATA_W-1:0] rfA, rfB, opA, opB;

  logic              s1Valid, s1Legal;
  logic [5:0]        s1Funct;
  logic [4:0]        s1Shamt, s1Rd;
  logic [IDX_W-1:0]  s1RdIdx;
  logic [DATA_W-1:0] s1A, s1B;

  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
  logic [DATA_W:0]   wide;

  logic              outValidQ, outZeroQ, outCarryQ, outIllegalQ;
  logic [DATA_W-1:0] outDataQ;
  logic [4:0]        outRdQ;

  assign rsIdx = regIdx(instr[25:21]);
  assign rtIdx = regIdx(instr[20:16]);
  assign rdIdx = regIdx(instr[15:11]);

  always_comb begin
    inLegal = 1'b0;
    case (instr[5:0])
      F_ADD, F_SUBU, F_AND, F_OR, F_SLT, F_SLL, F_SRL: inLegal = (instr[31:26] == 6'd0);
      default: inLegal = 1'b0;
    endcase
  end

  assign rfA = (rsIdx == '0) ? '0 : regs[rsIdx];
  assign rfB = (rtIdx == '0) ? '0 : regs[rtIdx];

  // The S1 instruction writes back at the same edge that captures the next one, so its rd is still stale in the array.
  assign rsHit = s1Valid && (s1RdIdx != '0) && (s1RdIdx == rsIdx);
  assign rtHit = s1Valid && (s1RdIdx != '0) && (s1RdIdx == rtIdx);

`ifdef PIPE_ALU_FWD_EN
  assign stall = 1'b0;
  assign opA   = (rsHit && s1Legal) ? aluRes : rfA;
  assign opB   = (rtHit && s1Legal) ? aluRes : rfB;
`else
  assign stall = rsHit || rtHit;
  assign opA   = rfA;
  assign opB   = rfB;
`endif

  assign in_ready = !rst && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    wide     = '0;
    case (s1Funct)
      F_ADD: begin
        wide     = {1'b0, s1A} + {1'b0, s1B};
        aluRes   = wide[DATA_W-1:0];
        aluCarry = wide[DATA_W];
      end
      F_SUBU: begin
        aluRes   = s1A - s1B;
        aluCarry = (s1A < s1B);
      end
      F_AND: aluRes = s1A & s1B;
      F_OR:  aluRes = s1A | s1B;
      F_SLT: aluRes = {{(DATA_W-1){1'b0}}, ($signed(s1A) < $signed(s1B))};
      F_SLL: begin
        // Extra bit above the MSB catches the last bit shifted out.
        if ({1'b0, s1Shamt} < SHIFT_LIMIT) begin
          wide     = {1'b0, s1B} << s1Shamt;
          aluRes   = wide[DATA_W-1:0];
          aluCarry = wide[DATA_W];
        end
      end
      F_SRL: begin
        if ({1'b0, s1Shamt} < SHIFT_LIMIT) begin
          wide     = {s1B, 1'b0} >> s1Shamt;
          aluRes   = wide[DATA_W:1];
          aluCarry = wide[0];
        end
      end
      default: ;
    endcase
    if (!s1Legal) begin
      aluRes   = '0;
      aluCarry = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid     <= 1'b0;
      outValidQ   <= 1'b0;
      outDataQ    <= '0;
      outZeroQ    <= 1'b0;
      outCarryQ   <= 1'b0;
      outRdQ      <= '0;
      outIllegalQ <= 1'b0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Legal <= inLegal;
        s1Funct <= instr[5:0];
        s1Shamt <= instr[10:6];
        s1Rd    <= instr[15:11];
        s1RdIdx <= rdIdx;
        s1A     <= opA;
        s1B     <= opB;
      end
      outValidQ <= s1Valid;
      if (s1Valid) begin
        outDataQ    <= aluRes;
        outZeroQ    <= (aluRes == '0);
        outCarryQ   <= aluCarry;
        outRdQ      <= s1Rd;
        outIllegalQ <= !s1Legal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && s1Valid && s1Legal && (s1RdIdx != '0)) regs[s1RdIdx] <= aluRes;
  end

  assign out_valid   = outValidQ && !rst;
  assign out_data    = rst ? '0 : outDataQ;
  assign out_zero    = outZeroQ && !rst;
  assign out_carry   = outCarryQ && !rst;
  assign out_rd      = rst ? 5'd0 : outRdQ;
  assign out_illegal = outIllegalQ && !rst;

endmodule

// File: tb/tb_pipelined_comp_alu.sv
// tb/tb_pipelined_comp_alu.sv - randomized and directed bench for pipelined_comp_alu against an in-order reference model
module tb_pipelined_comp_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_carry;
  logic [4:0]  out_rd;
  logic        out_illegal;

  pipelined_comp_alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_data(out_data), .out_zero(out_zero), .out_carry(out_carry),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        zero;
    logic        carry;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mr [32];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        prevAcc = 1'b0;
  logic [31:0] prevIns = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Architectural execution: each accepted instruction sees every earlier one completed.
  task automatic refExec(input logic [31:0] ins, output exp_t e);
    logic [31:0] a, b, r;
    logic [63:0] s;
    logic        c, legal;
    int          sh;
    a = (ins[25:21] == 5'd0) ? 32'd0 : mr[ins[25:21]];
    b = (ins[20:16] == 5'd0) ? 32'd0 : mr[ins[20:16]];
    sh = int'(ins[10:6]);
    legal = (ins[31:26] == 6'd0);
    r = '0;
    c = 1'b0;
    case (ins[5:0])
      6'h20: begin s = {32'd0, a} + {32'd0, b}; r = s[31:0]; c = s[32]; end
      6'h23: begin r = a - b; c = (a < b); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: begin r = b << sh; c = (sh == 0) ? 1'b0 : b[32-sh]; end
      6'h02: begin r = b >> sh; c = (sh == 0) ? 1'b0 : b[sh-1]; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin r = '0; c = 1'b0; end
    e.due = cyc + 1;
    e.data = r;
    e.zero = (r == 32'd0);
    e.carry = c;
    e.rd = ins[15:11];
    e.ill = !legal;
    if (legal && ins[15:11] != 5'd0) mr[ins[15:11]] = r;
  endtask

  function automatic logic expReady(input logic [31:0] ins);
    logic hz;
    hz = prevAcc && (prevIns[15:11] != 5'd0) &&
         ((prevIns[15:11] == ins[25:21]) || (prevIns[15:11] == ins[20:16]));
    if (rst) return 1'b0;
`ifdef PIPE_ALU_FWD_EN
    return 1'b1;
`else
    return !hz;
`endif
  endfunction

  task automatic checkOut();
    exp_t e;
    if (rst) begin
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_zero", out_zero, 0);
      check("rst_carry", out_carry, 0);
      check("rst_rd", out_rd, 0);
      check("rst_illegal", out_illegal, 0);
    end else if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      check("out_valid", out_valid, 1);
      check("out_data", out_data, e.data);
      check("out_zero", out_zero, e.zero);
      check("out_carry", out_carry, e.carry);
      check("out_rd", out_rd, e.rd);
      check("out_illegal", out_illegal, e.ill);
    end else begin
      check("idle_valid", out_valid, 0);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, output logic acc);
    exp_t e;
    in_valid = v;
    instr = ins;
    #1;
    check("in_ready", in_ready, expReady(ins));
    acc = v && in_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      expQ.delete();
      acc = 1'b0;
    end else if (acc) begin
      refExec(ins, e);
      expQ.push_back(e);
    end
    prevAcc = acc;
    prevIns = ins;
    @(negedge clk);
    checkOut();
  endtask

  task automatic issue(input logic [31:0] ins);
    logic acc;
    int   tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 4) begin
      cycle(1'b1, ins, acc);
      tries++;
    end
    check("issue_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, acc);
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] pool [8];
    logic [5:0] fns [8];
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd13, 5'd30, 5'd31};
    fns  = '{6'h20, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
    return rtype(($urandom_range(0, 15) == 0) ? 6'd1 : 6'd0,
                 pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                 5'($urandom_range(0, 31)), fns[$urandom_range(0, 7)]);
  endfunction

  logic [31:0] ins;
  logic [31:0] old7;
  logic        acc;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mr[i] = $urandom;
      dut.regs[i] = mr[i];
    end
    mr[0] = 32'h0;          dut.regs[0] = 32'h0;
    mr[31] = 32'hFFFFFFFF;  dut.regs[31] = 32'hFFFFFFFF;
    mr[30] = 32'h7F7F7F7F;  dut.regs[30] = 32'h7F7F7F7F;
    mr[13] = 32'h12345678;  dut.regs[13] = 32'h12345678;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    issue(rtype(6'd0, 5'd0, 5'd30, 5'd1, 5'd0, 6'h24));
    issue(rtype(6'd0, 5'd31, 5'd30, 5'd2, 5'd0, 6'h23));
    issue(rtype(6'd0, 5'd30, 5'd31, 5'd3, 5'd0, 6'h23));
    issue(rtype(6'd0, 5'd0, 5'd31, 5'd4, 5'd1, 6'h02));
    issue(rtype(6'd0, 5'd0, 5'd31, 5'd8, 5'd1, 6'h00));
    issue(rtype(6'd0, 5'd0, 5'd31, 5'd9, 5'd0, 6'h00));
    issue(rtype(6'd0, 5'd31, 5'd31, 5'd5, 5'd0, 6'h20));
    issue(rtype(6'd0, 5'd5, 5'd0, 5'd6, 5'd0, 6'h25));
    issue(rtype(6'd1, 5'd31, 5'd31, 5'd10, 5'd0, 6'h20));
    issue(rtype(6'd0, 5'd31, 5'd31, 5'd11, 5'd0, 6'h3F));
    issue(rtype(6'd0, 5'd31, 5'd30, 5'd0, 5'd0, 6'h20));
    idle(3);
    check("R1_after_and", dut.regs[1], 32'h0);
    check("R6_after_fwd", dut.regs[6], 32'hFFFFFFFE);

    old7 = mr[7];
    issue(rtype(6'd0, 5'd13, 5'd13, 5'd7, 5'd0, 6'h20));
    rst = 1'b1;
    cycle(1'b0, '0, acc);
    rst = 1'b0;
    mr[7] = old7;
    idle(3);
    check("R7_after_reset", dut.regs[7], old7);

    for (int n = 0; n < 400; n++) begin
      ins = randInstr();
      cycle($urandom_range(0, 9) < 8, ins, acc);
    end
    idle(4);

    for (int i = 0; i < 32; i++) check($sformatf("R%0d_final", i), dut.regs[i], mr[i]);
    check("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
